store_buffer: RTL and testbench

- Parametrised store buffer between the pipeline's execute stage and data memory.
- Generalises the current single-entry store→load forward into a DEPTH-entry circular queue with three behaviours:
  - youngest-match load forwarding;
  - same-address store coalescing;
  - back-pressured drain to memory, one write per cycle.
- Lets stores retire without waiting on the memory write port and removes the load-after-store flush case.

---
 rtl/store_buffer.sv | 164 ++++++++++++++++
 tb/tb_store_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer between the execute stage and data memory.
// A DEPTH-entry circular queue of pending word stores that supports three
// behaviours:
//   - combinational forwarding of the youngest matching store to loads;
//   - merging of a store into the youngest entry when the addresses match;
//   - in-order drain to memory, at most one write per cycle, back-pressured by
//     i_mem_ready.
// DEPTH must be a power of two and at least 2. The head and tail pointers then
// wrap naturally at log2(DEPTH) bits.

module store_buffer #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_st_valid,
   output logic              o_st_ready,
   input  logic [ADDR_W-1:0] i_st_addr,
   input  logic [DATA_W-1:0] i_st_data,
   input  logic [ADDR_W-1:0] i_ld_addr,
   output logic              o_ld_hit,
   output logic [DATA_W-1:0] o_ld_data,
   output logic              o_mem_wen,
   output logic [ADDR_W-1:0] o_mem_waddr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic              i_mem_ready,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_empty,
   output logic              o_full
);

   localparam int PTR_W = $clog2(DEPTH);

   // Entry storage. Only the valid bits are reset; address and data are
   // meaningless while their valid bit is clear.
   logic [DEPTH-1:0]  r_valid;
   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];

   // Queue bookkeeping. The count is kept in its own register so that
   // full and empty never need to be decoded from the pointers.
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;

   logic              w_empty;
   logic              w_full;
   logic              w_drainFire;
   logic              w_stReady;
   logic              w_accept;
   logic [PTR_W-1:0]  w_youngest;
   logic              w_youngestDraining;
   logic              w_coalesce;
   logic              w_enqueue;
   logic              w_ldHit;
   logic [DATA_W-1:0] w_ldData;

   // Occupancy flags come straight from the count register.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));

   // The head entry is always on offer to memory while anything is buffered.
   // A ready pulse while empty does nothing because w_drainFire stays low.
   assign w_drainFire = !w_empty && i_mem_ready;

   // A full buffer can still take a store in the same cycle that it drains.
   // This puts i_mem_ready on a combinational path to o_st_ready on purpose.
   assign w_stReady = !w_full || w_drainFire;
   assign w_accept  = i_st_valid && w_stReady;

   // Only the youngest entry is a merge candidate. Merging into an older
   // entry would move that store ahead of younger stores to other addresses
   // and break program order at memory. The youngest entry is also
   // excluded when it is the head and is leaving this cycle, because
   // otherwise the new data would be lost with it.
   assign w_youngest         = r_tail - PTR_W'(1);
   assign w_youngestDraining = w_drainFire && (w_youngest == r_head);
   assign w_coalesce         = w_accept && !w_empty
                               && (i_st_addr == r_addr[w_youngest])
                               && !w_youngestDraining;
   assign w_enqueue          = w_accept && !w_coalesce;

   // Head and tail pointers plus the occupancy count. A merge leaves the
   // tail and the count unchanged. A drain and an enqueue in the same cycle
   // also leave the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_drainFire) begin
            r_head <= r_head + PTR_W'(1);
         end
         if (w_enqueue) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_enqueue && !w_drainFire) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_drainFire && !w_enqueue) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Valid bits. Reset discards every pending store at once. When the
   // buffer is full and drains and enqueues together, tail equals head.
   // The later enqueue assignment then wins, so the freed slot is
   // immediately reused.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         if (w_drainFire) begin
            r_valid[r_head] <= 1'b0;
         end
         if (w_enqueue) begin
            r_valid[r_tail] <= 1'b1;
         end
      end
   end

   // Address and data payload. A new entry writes both fields. A merge only
   // replaces the data of the youngest entry.
   always_ff @(posedge clk) begin
      if (w_enqueue) begin
         r_addr[r_tail] <= i_st_addr;
         r_data[r_tail] <= i_st_data;
      end else if (w_coalesce) begin
         r_data[w_youngest] <= i_st_data;
      end
   end

   // Load lookup. The scan walks from the oldest entry to the youngest, so
   // the last match seen is the youngest and its data wins. A store
   // being accepted this cycle is not yet in the array and stays invisible.
   // The head entry still matches during its drain cycle, because memory
   // only takes the value at the coming edge.
   always_comb begin
      w_ldHit  = 1'b0;
      w_ldData = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[r_head + PTR_W'(i)]
             && (r_addr[r_head + PTR_W'(i)] == i_ld_addr)) begin
            w_ldHit  = 1'b1;
            w_ldData = r_data[r_head + PTR_W'(i)];
         end
      end
   end

   assign o_st_ready  = w_stReady;
   assign o_ld_hit    = w_ldHit;
   assign o_ld_data   = w_ldData;
   assign o_mem_wen   = !w_empty;
   assign o_mem_waddr = r_addr[r_head];
   assign o_mem_wdata = r_data[r_head];
   assign o_count     = r_count;
   assign o_empty     = w_empty;
   assign o_full      = w_full;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer. A queue-based reference model predicts every output
// on each falling edge. Directed scenarios add hand-computed expectations for
// the memory write stream and for key flags.

module tb_store_buffer;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic              clk;
   logic              rst_n;
   logic              i_st_valid;
   logic              o_st_ready;
   logic [ADDR_W-1:0] i_st_addr;
   logic [DATA_W-1:0] i_st_data;
   logic [ADDR_W-1:0] i_ld_addr;
   logic              o_ld_hit;
   logic [DATA_W-1:0] o_ld_data;
   logic              o_mem_wen;
   logic [ADDR_W-1:0] o_mem_waddr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic              i_mem_ready;
   logic [CNT_W-1:0]  o_count;
   logic              o_empty;
   logic              o_full;

   int checks = 0;
   int errors = 0;

   // Reference contents, oldest first.
   entry_t mq[$];

   // Writes that the DUT actually hands to memory, in order.
   logic [ADDR_W-1:0] logAddr[$];
   logic [DATA_W-1:0] logData[$];

   store_buffer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_st_valid(i_st_valid), .o_st_ready(o_st_ready),
      .i_st_addr(i_st_addr), .i_st_data(i_st_data),
      .i_ld_addr(i_ld_addr), .o_ld_hit(o_ld_hit), .o_ld_data(o_ld_data),
      .o_mem_wen(o_mem_wen), .o_mem_waddr(o_mem_waddr),
      .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready),
      .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkWrite(input int idx, input logic [31:0] a, input logic [31:0] d);
      if (idx < logAddr.size()) begin
         checkOutput("wrAddr", 32'(logAddr[idx]), a);
         checkOutput("wrData", 32'(logData[idx]), d);
      end else begin
         checks++;
         errors++;
         $display("[TB] FAIL wrMissing: write %0d absent, log holds %0d", idx, logAddr.size());
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic mr,
                                input logic [ADDR_W-1:0] la);
      i_st_valid  = v;
      i_st_addr   = a;
      i_st_data   = d;
      i_mem_ready = mr;
      i_ld_addr   = la;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clearLog();
      logAddr.delete();
      logData.delete();
   endtask

   // One clock edge of the queue model.
   // The rules are:
   //   - drain pops the oldest entry;
   //   - a store merges only into the youngest entry that survives the edge;
   //   - any other accepted store is appended.
   task automatic modelStep();
      int     n = mq.size();
      bit     drain;
      bit     accept;
      bit     coal;
      entry_t e;
      drain  = (n > 0) && (i_mem_ready === 1'b1);
      accept = (i_st_valid === 1'b1) && ((n < DEPTH) || drain);
      coal   = accept && (n > 0) && (mq[n-1].addr == i_st_addr) && !(drain && n == 1);
      if (drain) void'(mq.pop_front());
      if (coal) begin
         e      = mq.pop_back();
         e.data = i_st_data;
         mq.push_back(e);
      end else if (accept) begin
         e.addr = i_st_addr;
         e.data = i_st_data;
         mq.push_back(e);
      end
   endtask

   // Model state follows the clock and is emptied by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mq.delete();
      else        modelStep();
   end

   // Compare process: mid-cycle, check every output against the model and log
   // the writes that will fire at the coming edge.
   always @(negedge clk) begin
      int                n;
      logic              expHit;
      logic [DATA_W-1:0] expLd;
      n      = mq.size();
      expHit = 1'b0;
      expLd  = '0;
      for (int i = n - 1; i >= 0; i--) begin
         if (!expHit && mq[i].addr == i_ld_addr) begin
            expHit = 1'b1;
            expLd  = mq[i].data;
         end
      end
      checkOutput("count",   32'(o_count),    32'(n));
      checkOutput("empty",   32'(o_empty),    32'(n == 0));
      checkOutput("full",    32'(o_full),     32'(n == DEPTH));
      checkOutput("memWen",  32'(o_mem_wen),  32'(n > 0));
      checkOutput("stReady", 32'(o_st_ready), 32'((n < DEPTH) || (n > 0 && i_mem_ready === 1'b1)));
      checkOutput("ldHit",   32'(o_ld_hit),   32'(expHit));
      checkOutput("ldData",  32'(o_ld_data),  32'(expLd));
      if (n > 0) begin
         checkOutput("memAddr", 32'(o_mem_waddr), 32'(mq[0].addr));
         checkOutput("memData", 32'(o_mem_wdata), 32'(mq[0].data));
      end
      if (o_mem_wen === 1'b1 && i_mem_ready === 1'b1 && rst_n === 1'b1) begin
         logAddr.push_back(o_mem_waddr);
         logData.push_back(o_mem_wdata);
      end
   end

   // Runaway guard.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: actual no finish required finish");
      $fatal(1, "[TB] timeout");
   end

   // Directed scenarios.
   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      tick(2);
      rst_n = 1'b1;
      #1;
      checkOutput("rstWen",     32'(o_mem_wen),  32'h0);
      checkOutput("rstEmpty",   32'(o_empty),    32'h1);
      checkOutput("rstCount",   32'(o_count),    32'h0);
      checkOutput("rstStReady", 32'(o_st_ready), 32'h1);
      checkOutput("rstFull",    32'(o_full),     32'h0);
      tick(2);

      // Fill to full with memory stalled, hold a fifth store, then release
      // memory for one cycle.
      $display("[TB] fill and full-drain-store");
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, ADDR_W'(16 * i), DATA_W'(16'hD000 + i), 1'b0, '0);
         tick(1);
      end
      applyStimulus(1'b1, 15'h050, 16'hD005, 1'b0, '0);
      #1;
      checkOutput("fullFlag",    32'(o_full),     32'h1);
      checkOutput("fullStReady", 32'(o_st_ready), 32'h0);
      tick(2);
      checkOutput("heldCount", 32'(o_count), 32'h4);
      i_mem_ready = 1'b1;
      #1;
      checkOutput("drainStReady", 32'(o_st_ready),  32'h1);
      checkOutput("drainHead",    32'(o_mem_waddr), 32'h010);
      tick(1);
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      #1;
      checkOutput("swapCount", 32'(o_count), 32'h4);
      checkOutput("swapHead",  32'(o_mem_waddr), 32'h020);
      i_mem_ready = 1'b1;
      tick(5);
      checkOutput("fillLogSize", 32'(logAddr.size()), 32'd5);
      checkWrite(0, 32'h010, 32'hD001);
      checkWrite(1, 32'h020, 32'hD002);
      checkWrite(4, 32'h050, 32'hD005);
      checkOutput("fillEmpty", 32'(o_empty), 32'h1);

      // Merge of two stores to the same address.
      $display("[TB] coalesce");
      clearLog();
      applyStimulus(1'b1, 15'h100, 16'hAAAA, 1'b0, '0);
      tick(1);
      applyStimulus(1'b1, 15'h100, 16'hBBBB, 1'b0, '0);
      tick(1);
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      #1;
      checkOutput("coalCount", 32'(o_count),     32'h1);
      checkOutput("coalData",  32'(o_mem_wdata), 32'hBBBB);
      i_mem_ready = 1'b1;
      tick(3);
      checkOutput("coalLogSize", 32'(logAddr.size()), 32'd1);
      checkWrite(0, 32'h100, 32'hBBBB);

      // Youngest-match forwarding across a non-adjacent repeat.
      $display("[TB] lookup");
      applyStimulus(1'b1, 15'h200, 16'h1111, 1'b0, '0);
      tick(1);
      applyStimulus(1'b1, 15'h300, 16'h2222, 1'b0, '0);
      tick(1);
      applyStimulus(1'b1, 15'h200, 16'h3333, 1'b0, '0);
      tick(1);
      applyStimulus(1'b0, '0, '0, 1'b0, 15'h200);
      #1;
      checkOutput("lkCount", 32'(o_count),   32'h3);
      checkOutput("lkHit",   32'(o_ld_hit),  32'h1);
      checkOutput("lkData",  32'(o_ld_data), 32'h3333);
      i_ld_addr = 15'h400;
      #1;
      checkOutput("lkMissHit",  32'(o_ld_hit),  32'h0);
      checkOutput("lkMissData", 32'(o_ld_data), 32'h0);

      // Reset mid-stream with three pending entries.
      $display("[TB] mid-stream reset");
      tick(1);
      clearLog();
      i_mem_ready = 1'b1;
      #1;
      checkOutput("preRstWen", 32'(o_mem_wen), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstCount", 32'(o_count),   32'h0);
      checkOutput("midRstWen",   32'(o_mem_wen), 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      checkOutput("postRstWrites", 32'(logAddr.size()), 32'd0);

      // Move head to index 3, then enqueue three stores so the tail wraps.
      $display("[TB] wrap");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, ADDR_W'(15'h500 + 16 * i), DATA_W'(16'h5000 + i), 1'b0, '0);
         tick(1);
      end
      applyStimulus(1'b0, '0, '0, 1'b1, '0);
      tick(3);
      clearLog();
      applyStimulus(1'b1, 15'h600, 16'hA001, 1'b0, '0);
      tick(1);
      applyStimulus(1'b1, 15'h610, 16'hA002, 1'b0, '0);
      tick(1);
      applyStimulus(1'b1, 15'h600, 16'hA003, 1'b0, '0);
      tick(1);
      applyStimulus(1'b0, '0, '0, 1'b0, 15'h600);
      #1;
      checkOutput("wrapCount",  32'(o_count),   32'h3);
      checkOutput("wrapLdData", 32'(o_ld_data), 32'hA003);
      i_mem_ready = 1'b1;
      tick(4);
      checkOutput("wrapLogSize", 32'(logAddr.size()), 32'd3);
      checkWrite(0, 32'h600, 32'hA001);
      checkWrite(1, 32'h610, 32'hA002);
      checkWrite(2, 32'h600, 32'hA003);

      // The head entry stays visible to loads during its drain cycle.
      $display("[TB] head drain lookup");
      applyStimulus(1'b1, 15'h700, 16'h7777, 1'b0, '0);
      tick(1);
      applyStimulus(1'b0, '0, '0, 1'b1, 15'h700);
      #1;
      checkOutput("hdHit",  32'(o_ld_hit),  32'h1);
      checkOutput("hdData", 32'(o_ld_data), 32'h7777);
      tick(1);
      checkOutput("hdHitAfter", 32'(o_ld_hit), 32'h0);
      checkOutput("hdEmpty",    32'(o_empty),  32'h1);

      // A store to the address of a single draining entry is not merged.
      $display("[TB] no merge into draining head");
      clearLog();
      applyStimulus(1'b1, 15'h800, 16'h0001, 1'b0, '0);
      tick(1);
      applyStimulus(1'b1, 15'h800, 16'h0002, 1'b1, '0);
      tick(1);
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      #1;
      checkOutput("nmCount", 32'(o_count),     32'h1);
      checkOutput("nmData",  32'(o_mem_wdata), 32'h0002);
      i_mem_ready = 1'b1;
      tick(3);
      checkOutput("nmLogSize", 32'(logAddr.size()), 32'd2);
      checkWrite(0, 32'h800, 32'h0001);
      checkWrite(1, 32'h800, 32'h0002);

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
